// File: rtl/div_if.sv
// Handshake and operand bus between the execute stage (master) and the
// multi-cycle divider (slave).
interface div_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per
// cycle on operand magnitudes, sign-corrected on completion.
module div #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   rem;
  logic               neg_dividend;
  logic               neg_divisor;
  logic [2*WIDTH-1:0] result;
  logic               ready;

  logic [WIDTH:0]     rem_shift;
  logic               fits;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                input logic neg);
    return neg ? (~x + WIDTH'(1)) : x;
  endfunction

  // The partial remainder keeps its top bit so divisors >= 2^(WIDTH-1)
  // still compare correctly; the subtraction result always fits in WIDTH.
  always_comb begin
    rem_shift = {rem, dividend[WIDTH-1]};
    fits      = rem_shift >= {1'b0, divisor};
    rem_next  = fits ? (rem_shift[WIDTH-1:0] - divisor) : rem_shift[WIDTH-1:0];
    quo_next  = {dividend[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= FREE;
      cnt          <= '0;
      dividend     <= '0;
      divisor      <= '0;
      rem          <= '0;
      neg_dividend <= 1'b0;
      neg_divisor  <= 1'b0;
      result       <= '0;
      ready        <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready  <= 1'b0;
          result <= '0;
          rem    <= '0;
          cnt    <= '0;
          if (bus.start_i && !bus.annul_i) begin
            neg_dividend <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
            neg_divisor  <= bus.signed_div_i & bus.opdata2_i[WIDTH-1];
            divisor      <= cond_neg(bus.opdata2_i,
                                     bus.signed_div_i & bus.opdata2_i[WIDTH-1]);
            if (bus.opdata2_i == '0) begin
              // Raw dividend kept: it is returned unchanged as the remainder.
              dividend <= bus.opdata1_i;
              state    <= BY_ZERO;
            end else begin
              dividend <= cond_neg(bus.opdata1_i,
                                   bus.signed_div_i & bus.opdata1_i[WIDTH-1]);
              state    <= ON;
            end
          end
        end

        BY_ZERO: begin
          if (bus.annul_i || !bus.start_i) begin
            state <= FREE;
          end else begin
            result <= {dividend, {WIDTH{1'b1}}};
            ready  <= 1'b1;
            state  <= END;
          end
        end

        ON: begin
          if (bus.annul_i || !bus.start_i) begin
            state <= FREE;
          end else begin
            // Quotient bits shift into the vacated low end of the dividend.
            dividend <= quo_next;
            rem      <= rem_next;
            cnt      <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
              result <= {cond_neg(rem_next, neg_dividend),
                         cond_neg(quo_next, neg_dividend ^ neg_divisor)};
              ready  <= 1'b1;
              state  <= END;
            end
          end
        end

        END: begin
          if (!bus.start_i) begin
            result <= '0;
            ready  <= 1'b0;
            state  <= FREE;
          end
        end

        default: state <= FREE;
      endcase
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;

endmodule

// File: tb/tb_div.sv
// Directed bench for the multi-cycle divider: vector table plus hand-written
// abort, annul and asynchronous reset sequences.
module tb_div;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_if #(.WIDTH(32)) bus ();

  div #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation, scramble the operands after the launch edge,
  // and count edges until ready (bounded).
  task automatic run_op(input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, output logic [63:0] res,
                        output int lat);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    lat = 0;
    res = '0;
    while (lat < 40) begin
      step();
      lat++;
      if (lat == 1) begin
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = ~sgn;
      end
      if (bus.ready_o === 1'b1) begin
        res = bus.result_o;
        break;
      end
    end
  endtask

  initial begin
    logic [63:0] res;
    int          lat;
    logic        seen;

    vecs.push_back('{"u100_7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33});
    vecs.push_back('{"s-7_2",     1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   33});
    vecs.push_back('{"s7_-2",     1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          33});
    vecs.push_back('{"sdivzero",  1'b1, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   2});
    vecs.push_back('{"s_ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          33});
    vecs.push_back('{"u_ovfops",  1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   33});
    vecs.push_back('{"u_bigdiv",  1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          32'd1,          33});
    vecs.push_back('{"s-100_-7",  1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   33});
    vecs.push_back('{"udivzero",  1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          2});
    vecs.push_back('{"u3_5",      1'b0, 32'd3,          32'd5,          32'd0,          32'd3,          33});

    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;

    repeat (2) step();
    check("reset_result", bus.result_o, 64'd0);
    check("reset_ready",  {63'd0, bus.ready_o}, 64'd0);
    rst = 1'b1;
    step();

    foreach (vecs[i]) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, res, lat);
      check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      check({vecs[i].name, "_q"},   res[31:0],  vecs[i].q);
      check({vecs[i].name, "_r"},   res[63:32], vecs[i].r);
      step();
      check({vecs[i].name, "_hold"}, {bus.ready_o, bus.result_o},
            {1'b1, vecs[i].r, vecs[i].q});
      bus.start_i = 1'b0;
      step();
      check({vecs[i].name, "_drop"}, {bus.ready_o, bus.result_o}, 65'd0);
    end

    // Annul ten edges into the iteration, then launch a fresh operation.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    seen = 1'b0;
    repeat (11) begin
      step();
      seen |= bus.ready_o;
    end
    bus.annul_i = 1'b1;
    step();
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    seen |= bus.ready_o;
    repeat (3) begin
      step();
      seen |= bus.ready_o;
    end
    check("annul_noready", {63'd0, seen}, 64'd0);
    run_op(1'b0, 32'hFFFFFFFF, 32'h10, res, lat);
    check("post_annul_lat", lat, 33);
    check("post_annul_q", res[31:0],  32'h0FFFFFFF);
    check("post_annul_r", res[63:32], 32'hF);
    bus.start_i = 1'b0;
    step();

    // Annul wins over start in FREE: nothing may launch.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      step();
      seen |= bus.ready_o;
    end
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    repeat (3) begin
      step();
      seen |= bus.ready_o;
    end
    check("annul_priority", {63'd0, seen}, 64'd0);

    // Dropping start mid-iteration abandons the operation.
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    repeat (5) step();
    bus.start_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      step();
      seen |= bus.ready_o;
    end
    check("start_drop_abort", {63'd0, seen}, 64'd0);

    // Asynchronous reset between edges, mid-iteration and while holding a result.
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    bus.start_i   = 1'b1;
    repeat (6) step();
    #2 rst = 1'b0;
    #1;
    check("async_rst_on", {bus.ready_o, bus.result_o}, 65'd0);
    bus.start_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    run_op(1'b0, 32'd50, 32'd5, res, lat);
    check("pre_rst_end_q", res[31:0], 32'd10);
    #2 rst = 1'b0;
    #1;
    check("async_rst_end", {bus.ready_o, bus.result_o}, 65'd0);
    bus.start_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    run_op(1'b0, 32'd9, 32'd3, res, lat);
    check("after_rst_lat", lat, 33);
    check("after_rst_q", res[31:0],  32'd3);
    check("after_rst_r", res[63:32], 32'd0);
    bus.start_i = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
